// File: rtl/ahb_pkg.sv
// ahb_pkg
// Shared AHB encodings and the default-slave state type.
//   - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ)
//   - HRESP encodings (OKAY, ERROR)
//   - defslv_state_e : default-slave FSM states
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RESP1 = 2'd2,
    ST_RESP2 = 2'd3
  } defslv_state_e;

endpackage

// File: rtl/ahb_defslv_log.sv
// ahb_defslv_log
// Diagnostic log for unmapped AHB accesses: capture of the last access,
// saturating access counter and sticky interrupt.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   log_valid        : an access was accepted this cycle
//   log_addr/master/write : address-phase values of that access
//   clr              : one-cycle clear of counter and interrupt
//   cnt, irq         : saturating count, sticky interrupt
//   addr, master, write : values of the last logged access
module ahb_defslv_log #(
  parameter int ADDR_W = 32,
  parameter int MST_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              log_valid,
  input  logic [ADDR_W-1:0] log_addr,
  input  logic [MST_W-1:0]  log_master,
  input  logic              log_write,
  input  logic              clr,
  output logic [CNT_W-1:0]  cnt,
  output logic              irq,
  output logic [ADDR_W-1:0] addr,
  output logic [MST_W-1:0]  master,
  output logic              write
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              irq_q, irq_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [MST_W-1:0]  master_q, master_d;
  logic              write_q, write_d;

  // A new event beats a coincident clear: the counter restarts at 1 and
  // the interrupt stays raised.
  always_comb begin
    cnt_d    = cnt_q;
    irq_d    = irq_q;
    addr_d   = addr_q;
    master_d = master_q;
    write_d  = write_q;
    if (log_valid) begin
      addr_d   = log_addr;
      master_d = log_master;
      write_d  = log_write;
      irq_d    = 1'b1;
      if (clr)
        cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_MAX)
        cnt_d = cnt_q + CNT_W'(1);
    end else if (clr) begin
      cnt_d = '0;
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      irq_q    <= 1'b0;
      addr_q   <= '0;
      master_q <= '0;
      write_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      irq_q    <= irq_d;
      addr_q   <= addr_d;
      master_q <= master_d;
      write_q  <= write_d;
    end
  end

  assign cnt    = cnt_q;
  assign irq    = irq_q;
  assign addr   = addr_q;
  assign master = master_q;
  assign write  = write_q;

endmodule

// File: rtl/ahb_default_slave_ext.sv
// ahb_default_slave_ext
// AHB default slave for the decoder's unmapped select line. Answers every
// NONSEQ/SEQ transfer with a two-cycle ERROR (ERR_RESP=1) or an OKAY
// read-as-zero/write-ignored response (ERR_RESP=0), after WAIT_CYCLES
// wait states.
// Optional build macro AHB_DEFSLV_LOG_EN: when defined, unmapped accesses
// are logged (err_* outputs); otherwise err_* are tied to 0 and err_clr is
// ignored.
// Ports:
//   HCLK, HRESETn           : clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS, HWRITE, HMASTER, HREADY : AHB address phase
//   HREADYOUT, HRESP, HRDATA : AHB response (HRDATA always 0)
//   err_clr                 : clear pulse for err_cnt / err_irq
//   err_irq, err_cnt, err_addr, err_master, err_write : diagnostic log
module ahb_default_slave_ext #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MST_W       = 4,
  parameter int WAIT_CYCLES = 0,
  parameter int ERR_RESP    = 1,
  parameter int CNT_W       = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [MST_W-1:0]  HMASTER,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [DATA_W-1:0] HRDATA,
  input  logic              err_clr,
  output logic              err_irq,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] err_addr,
  output logic [MST_W-1:0]  err_master,
  output logic              err_write
);
  import ahb_pkg::*;

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("ahb_default_slave_ext: WAIT_CYCLES must be in 0..15");
    end
  endgenerate

  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);
  localparam defslv_state_e RESP_ST  = (ERR_RESP != 0) ? ST_RESP1 : ST_RESP2;
  localparam defslv_state_e ENTRY_ST = (WAIT_CYCLES > 0) ? ST_WAIT : RESP_ST;

  defslv_state_e state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          hreadyout_q, hreadyout_d;
  logic [1:0]    hresp_q, hresp_d;
  logic          accept;

  // Outputs are decoded from the next state and registered, so HREADYOUT
  // and HRESP never depend combinationally on the bus inputs.
  always_comb begin
    accept     = HSEL & HREADY & HTRANS[1] &
                 ((state_q == ST_IDLE) || (state_q == ST_RESP2));
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE, ST_RESP2: begin
        if (accept) begin
          state_d    = ENTRY_ST;
          wait_cnt_d = (ENTRY_ST == ST_WAIT) ? 4'd1 : 4'd0;
        end else begin
          state_d    = ST_IDLE;
          wait_cnt_d = 4'd0;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LIM) begin
          state_d    = RESP_ST;
          wait_cnt_d = 4'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ST_RESP1: state_d = ST_RESP2;
      default:  state_d = ST_IDLE;
    endcase
    hreadyout_d = !((state_d == ST_WAIT) || (state_d == ST_RESP1));
    hresp_d     = ((state_d == ST_RESP1) ||
                   ((state_d == ST_RESP2) && (ERR_RESP != 0))) ? HRESP_ERROR : HRESP_OKAY;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = '0;

  // HTRANS[0] only distinguishes NONSEQ from SEQ, which are handled alike.
  logic unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

`ifdef AHB_DEFSLV_LOG_EN
  ahb_defslv_log #(
    .ADDR_W(ADDR_W),
    .MST_W (MST_W),
    .CNT_W (CNT_W)
  ) u_log (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .log_valid (accept),
    .log_addr  (HADDR),
    .log_master(HMASTER),
    .log_write (HWRITE),
    .clr       (err_clr),
    .cnt       (err_cnt),
    .irq       (err_irq),
    .addr      (err_addr),
    .master    (err_master),
    .write     (err_write)
  );
`else
  assign err_cnt    = '0;
  assign err_irq    = 1'b0;
  assign err_addr   = '0;
  assign err_master = '0;
  assign err_write  = 1'b0;

  logic unused_log_inputs;
  assign unused_log_inputs = ^{err_clr, HADDR, HMASTER, HWRITE};
`endif

endmodule

// File: tb/tb_ahb_default_slave_ext.sv
// Bench for ahb_default_slave_ext. Four instances with different
// parameters share the bus inputs; each has its own HSEL bit and its
// HREADY tied to its own HREADYOUT. Log expectations follow the
// AHB_DEFSLV_LOG_EN build setting.
module tb_ahb_default_slave_ext;
  import ahb_pkg::*;

`ifdef AHB_DEFSLV_LOG_EN
  localparam bit LOG_ON = 1'b1;
`else
  localparam bit LOG_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [3:0]  hmaster;
  logic        err_clr;

  logic        rdy0, rdy1, rdy2, rdy3;
  logic [1:0]  resp0, resp1, resp2, resp3;
  logic [31:0] rdata0, rdata1, rdata2, rdata3;
  logic        irq0, irq1, irq2, irq3;
  logic [7:0]  cnt0, cnt1, cnt2;
  logic [1:0]  cnt3;
  logic [31:0] eaddr0, eaddr1, eaddr2, eaddr3;
  logic [3:0]  emst0, emst1, emst2, emst3;
  logic        ewr0, ewr1, ewr2, ewr3;

  int vec_count  = 0;
  int fail_count = 0;

  ahb_default_slave_ext #(.WAIT_CYCLES(0), .ERR_RESP(1)) u0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HMASTER(hmaster), .HREADY(rdy0), .HREADYOUT(rdy0),
    .HRESP(resp0), .HRDATA(rdata0), .err_clr(err_clr), .err_irq(irq0),
    .err_cnt(cnt0), .err_addr(eaddr0), .err_master(emst0), .err_write(ewr0));

  ahb_default_slave_ext #(.WAIT_CYCLES(3), .ERR_RESP(1)) u1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HMASTER(hmaster), .HREADY(rdy1), .HREADYOUT(rdy1),
    .HRESP(resp1), .HRDATA(rdata1), .err_clr(err_clr), .err_irq(irq1),
    .err_cnt(cnt1), .err_addr(eaddr1), .err_master(emst1), .err_write(ewr1));

  ahb_default_slave_ext #(.WAIT_CYCLES(1), .ERR_RESP(0)) u2 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HMASTER(hmaster), .HREADY(rdy2), .HREADYOUT(rdy2),
    .HRESP(resp2), .HRDATA(rdata2), .err_clr(err_clr), .err_irq(irq2),
    .err_cnt(cnt2), .err_addr(eaddr2), .err_master(emst2), .err_write(ewr2));

  ahb_default_slave_ext #(.WAIT_CYCLES(0), .ERR_RESP(1), .CNT_W(2)) u3 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[3]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HMASTER(hmaster), .HREADY(rdy3), .HREADYOUT(rdy3),
    .HRESP(resp3), .HRDATA(rdata3), .err_clr(err_clr), .err_irq(irq3),
    .err_cnt(cnt3), .err_addr(eaddr3), .err_master(emst3), .err_write(ewr3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected log value: the value itself when logging is built in, else 0.
  function automatic logic [63:0] lg(input logic [63:0] v);
    return LOG_ON ? v : 64'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vec_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] sel, input logic [1:0] trans,
                               input logic wr, input logic [31:0] addr,
                               input logic [3:0] mst);
    hsel    = sel;
    htrans  = trans;
    hwrite  = wr;
    haddr   = addr;
    hmaster = mst;
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tables for the wait-state ERROR sequence on u1 (WAIT_CYCLES=3).
  logic b_rdy  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [1:0] b_resp [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
  // Expected counter of u3 (CNT_W=2) after each edge of the burst.
  logic [1:0] e_cnt [10] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};

  initial begin
    rst_n   = 1'b0;
    err_clr = 1'b0;
    applyStimulus(4'b0000, HTRANS_IDLE, 1'b0, 32'h0, 4'h0);
    #23;
    rst_n = 1'b1;
    tick();

    // Reset state
    checkOutput("rst_rdy",  rdy0, 1'b1);
    checkOutput("rst_resp", resp0, 2'b00);
    checkOutput("rst_cnt",  cnt0, 8'd0);
    checkOutput("rst_irq",  irq0, 1'b0);
    checkOutput("rst_addr", eaddr0, 32'h0);

    // Zero-wait ERROR on a write
    applyStimulus(4'b0001, HTRANS_NONSEQ, 1'b1, 32'h4000_0010, 4'd3);
    tick();
    applyStimulus(4'b0001, HTRANS_IDLE, 1'b0, 32'h0, 4'd0);
    checkOutput("a_rdy1",  rdy0, 1'b0);
    checkOutput("a_resp1", resp0, 2'b01);
    checkOutput("a_addr",  eaddr0, lg(32'h4000_0010));
    checkOutput("a_mst",   emst0, lg(4'd3));
    checkOutput("a_wr",    ewr0, lg(1'b1));
    checkOutput("a_cnt",   cnt0, lg(8'd1));
    checkOutput("a_irq",   irq0, lg(1'b1));
    tick();
    checkOutput("a_rdy2",  rdy0, 1'b1);
    checkOutput("a_resp2", resp0, 2'b01);
    tick();
    checkOutput("a_rdy3",  rdy0, 1'b1);
    checkOutput("a_resp3", resp0, 2'b00);

    // IDLE and BUSY with HSEL=1 are ignored
    applyStimulus(4'b0001, HTRANS_IDLE, 1'b0, 32'h4000_0020, 4'd1);
    tick();
    checkOutput("d_idle_rdy",  rdy0, 1'b1);
    checkOutput("d_idle_resp", resp0, 2'b00);
    applyStimulus(4'b0001, HTRANS_BUSY, 1'b0, 32'h4000_0020, 4'd1);
    tick();
    checkOutput("d_busy_rdy",  rdy0, 1'b1);
    checkOutput("d_busy_resp", resp0, 2'b00);
    checkOutput("d_cnt",       cnt0, lg(8'd1));

    // Three wait states then ERROR, HRDATA zero throughout
    applyStimulus(4'b0010, HTRANS_NONSEQ, 1'b0, 32'h0000_1234, 4'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) applyStimulus(4'b0010, HTRANS_IDLE, 1'b0, 32'h0, 4'd0);
      checkOutput($sformatf("b_rdy%0d", i), rdy1, b_rdy[i]);
      checkOutput($sformatf("b_resp%0d", i), resp1, b_resp[i]);
      checkOutput($sformatf("b_rdata%0d", i), rdata1, 32'h0);
    end
    checkOutput("b_wr", ewr1, 1'b0);

    // OKAY (RAZ/WI) after one wait state
    applyStimulus(4'b0100, HTRANS_NONSEQ, 1'b0, 32'h2000_0008, 4'd6);
    tick();
    applyStimulus(4'b0100, HTRANS_IDLE, 1'b0, 32'h0, 4'd0);
    checkOutput("c_rdy1",  rdy2, 1'b0);
    checkOutput("c_resp1", resp2, 2'b00);
    tick();
    checkOutput("c_rdy2",  rdy2, 1'b1);
    checkOutput("c_resp2", resp2, 2'b00);
    checkOutput("c_rdata", rdata2, 32'h0);
    checkOutput("c_cnt",   cnt2, lg(8'd1));
    checkOutput("c_mst",   emst2, lg(4'd6));
    tick();
    checkOutput("c_rdy3",  rdy2, 1'b1);

    // Back-to-back burst saturates a 2-bit counter
    applyStimulus(4'b1000, HTRANS_NONSEQ, 1'b0, 32'h8000_0000, 4'd2);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) htrans = HTRANS_SEQ;
      checkOutput($sformatf("e_rdy%0d", i), rdy3, logic'(i % 2));
      checkOutput($sformatf("e_resp%0d", i), resp3, 2'b01);
      checkOutput($sformatf("e_cnt%0d", i), cnt3, lg(e_cnt[i]));
    end
    applyStimulus(4'b1000, HTRANS_SEQ, 1'b1, 32'hDEAD_BEE0, 4'd5);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    applyStimulus(4'b1000, HTRANS_IDLE, 1'b0, 32'h0, 4'd0);
    checkOutput("e_clr_cnt",  cnt3, lg(2'd1));
    checkOutput("e_clr_irq",  irq3, lg(1'b1));
    checkOutput("e_clr_addr", eaddr3, lg(32'hDEAD_BEE0));
    checkOutput("e_clr_mst",  emst3, lg(4'd5));
    checkOutput("e_clr_rdy",  rdy3, 1'b0);
    tick();
    tick();
    checkOutput("e_cancel_rdy",  rdy3, 1'b1);
    checkOutput("e_cancel_resp", resp3, 2'b00);
    checkOutput("e_cancel_cnt",  cnt3, lg(2'd1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("e_alone_cnt",  cnt3, 2'd0);
    checkOutput("e_alone_irq",  irq3, 1'b0);
    checkOutput("e_alone_addr", eaddr3, lg(32'hDEAD_BEE0));

    // Asynchronous reset during RESP1
    applyStimulus(4'b0001, HTRANS_NONSEQ, 1'b0, 32'h4000_0100, 4'd7);
    tick();
    applyStimulus(4'b0001, HTRANS_IDLE, 1'b0, 32'h0, 4'd0);
    checkOutput("f_pre_rdy", rdy0, 1'b0);
    checkOutput("f_pre_cnt", cnt0, lg(8'd2));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("f_rst_rdy",  rdy0, 1'b1);
    checkOutput("f_rst_resp", resp0, 2'b00);
    checkOutput("f_rst_cnt",  cnt0, 8'd0);
    checkOutput("f_rst_irq",  irq0, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    checkOutput("f_post_rdy",  rdy0, 1'b1);
    checkOutput("f_post_resp", resp0, 2'b00);
    tick();
    checkOutput("f_post2_rdy",  rdy0, 1'b1);
    checkOutput("f_post2_resp", resp0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule

// File: doc/ahb_default_slave_ext.md
Name: ahb_default_slave_ext

Overview:
- Parametrised next-generation AHB default slave; sits on the decoder's default (unmapped) select line behind the interconnect.
- Completes NONSEQ/SEQ transfers with the spec-compliant two-cycle ERROR response, or, by mode, an OKAY read-as-zero/write-ignored response. Either response follows a configurable number of wait states.
- Logs unmapped accesses (count, address, master, direction) and raises a sticky interrupt for system diagnostics.

Parameters:
- ADDR_W, 32, HADDR width.
- DATA_W, 32, HRDATA width.
- MST_W, 4, HMASTER width.
- WAIT_CYCLES, 0, wait states (HREADYOUT=0, HRESP=OKAY) inserted before the response; 0..15.
- ERR_RESP, 1, 1 = ERROR response; 0 = OKAY response (RAZ/WI).
- CNT_W, 8, error counter width.

Ports:
- HCLK  in  1  AHB clock.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  default-slave select from the decoder.
- HADDR  in  ADDR_W  address.
- HTRANS  in  2  transfer type.
- HWRITE  in  1  direction.
- HMASTER  in  MST_W  master ID.
- HREADY  in  1  bus HREADY (muxed).
- HREADYOUT  out  1  slave ready.
- HRESP  out  2  00 = OKAY, 01 = ERROR.
- HRDATA  out  DATA_W  constant 0.
- err_clr  in  1  one-cycle pulse; clears err_cnt and err_irq.
- err_irq  out  1  sticky level interrupt.
- err_cnt  out  CNT_W  saturating logged-access count.
- err_addr  out  ADDR_W  HADDR of the last logged access.
- err_master  out  MST_W  HMASTER of the last logged access.
- err_write  out  1  HWRITE of the last logged access.

Behaviour:
- Single clock HCLK; asynchronous active-low reset HRESETn.
- Reset values: state IDLE, HREADYOUT=1, HRESP=00, wait counter 0, err_cnt 0, err_irq 0, err_addr 0, err_master 0, err_write 0.
- Accept condition: HSEL & HREADY & HTRANS[1] (NONSEQ or SEQ), sampled in IDLE or RESP2.
- IDLE or BUSY transfers, or HSEL=0: stay IDLE, OKAY, zero wait.
- FSM states:
  - IDLE
  - WAIT: HREADYOUT=0, HRESP=OKAY; counter runs 1..WAIT_CYCLES.
  - RESP1: HREADYOUT=0, HRESP=ERROR. Reachable only when ERR_RESP=1.
  - RESP2: HREADYOUT=1, HRESP = ERROR if ERR_RESP=1, else OKAY.
- Transitions:
  - From IDLE on accept: to WAIT if WAIT_CYCLES>0; otherwise to RESP1 (ERR_RESP=1) or RESP2 (ERR_RESP=0).
  - From WAIT: exit after WAIT_CYCLES cycles, to RESP1 or RESP2 as above.
  - RESP1 always goes to RESP2.
  - From RESP2 on accept: new transfer, same entry rules as from IDLE. Otherwise to IDLE.
- Latency from accept to completion (HREADYOUT high):
  - WAIT_CYCLES+2 cycles for ERROR.
  - WAIT_CYCLES+1 cycles for OKAY.
- HREADYOUT and HRESP are decoded from state only; no combinational path from inputs.
- HRDATA is always 0. Write data is ignored.
- Logging, in the cycle after accept:
  - err_addr, err_master and err_write load from the sampled address phase.
  - err_cnt increments, saturating at all-ones (no wrap).
  - err_irq is set.
- err_clr in the same cycle as a log update: the counter loads 1 and err_irq stays set (the new event wins). Capture registers update normally.
- err_clr alone: err_cnt=0, err_irq=0. Capture registers are kept.
- Master drops to IDLE during RESP2 (normal ERROR cancellation): return to IDLE, no new log.
- Reset asserted mid-transfer: immediate return to the reset values; no partial response.
- WAIT_CYCLES outside 0..15: elaboration error.

Optional Feature:
- AHB_DEFSLV_LOG_EN defined: capture registers, err_cnt and err_irq are implemented as above.
- Undefined: err_cnt, err_addr, err_master, err_write and err_irq are tied to 0, and err_clr is ignored. Bus response behaviour is unchanged.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS encodings: IDLE, BUSY, NONSEQ, SEQ.
  - HRESP encodings: OKAY, ERROR.
  - The state enum typedef.
- One natural sub-module, ahb_defslv_log: capture registers, saturating counter and interrupt; instantiated only under AHB_DEFSLV_LOG_EN.

Test Plan:
- WAIT_CYCLES=0, ERR_RESP=1; NONSEQ write to 0x4000_0010, HMASTER=3 -> next cycle HREADYOUT=0/HRESP=01, then HREADYOUT=1/HRESP=01; err_addr=0x4000_0010, err_master=3, err_write=1, err_cnt=1, err_irq=1.
- WAIT_CYCLES=3; NONSEQ read -> 3 cycles HREADYOUT=0/HRESP=00, then two-cycle ERROR; HRDATA=0 throughout.
- ERR_RESP=0, WAIT_CYCLES=1; NONSEQ read -> one wait cycle, then HREADYOUT=1/HRESP=00, HRDATA=0; err_cnt increments.
- IDLE and BUSY transfers with HSEL=1 -> HREADYOUT stays 1, HRESP=00, err_cnt unchanged.
- CNT_W=2; 5 back-to-back NONSEQ accepted in RESP2 -> err_cnt saturates at 3. err_clr coincident with the 6th log -> err_cnt=1, err_irq=1.
- HRESETn low during RESP1 -> asynchronously HREADYOUT=1, HRESP=00, err_cnt=0. After release, IDLE with no residual response.
